mips_test_monitor: RTL and testbench

Parametrised pass/fail monitor for MIPS core regression runs. It snoops the core's data-memory write port and keeps a shadow copy of N_CHECKS watched addresses. When the program writes the done flag, it compares every shadow against an expected table loaded beforehand. It reports pass, fail, timeout, error count and first failing slot on registered status outputs, so the same check works in simulation benches and in FPGA bring-up with LEDs.

---
 rtl/mips_test_monitor_pkg.sv | 13 +
 rtl/mips_test_monitor_if.sv | 33 +++
 rtl/mips_test_monitor_slot_file.sv | 51 +++++
 rtl/mips_test_monitor.sv | 118 +++++++++++
 tb/tb_mips_test_monitor.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_test_monitor_pkg.sv
// mips_tb_pkg: shared state encoding and width helpers for the test monitor
package mips_tb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} mon_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int timeout_w(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction
endpackage

// File: rtl/mips_test_monitor_if.sv
// mips_test_monitor_if: control, config, memory-snoop and status bundle of the monitor
interface mips_test_monitor_if
  import mips_tb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_CHECKS = 4
);
  localparam int IDX_W = idx_w(N_CHECKS);
  localparam int CNT_W = cnt_w(N_CHECKS);
  logic              i_start;
  logic              i_cfg_we;
  logic [IDX_W-1:0]  i_cfg_idx;
  logic [ADDR_W-1:0] i_cfg_addr;
  logic [DATA_W-1:0] i_cfg_data;
  logic              i_mem_we;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_pass;
  logic              o_timeout;
  logic [CNT_W-1:0]  o_err_count;
  logic [IDX_W-1:0]  o_first_fail_idx;
  modport master (
    output i_start, i_cfg_we, i_cfg_idx, i_cfg_addr, i_cfg_data, i_mem_we, i_mem_addr, i_mem_wdata,
    input  o_busy, o_done, o_pass, o_timeout, o_err_count, o_first_fail_idx
  );
  modport slave (
    input  i_start, i_cfg_we, i_cfg_idx, i_cfg_addr, i_cfg_data, i_mem_we, i_mem_addr, i_mem_wdata,
    output o_busy, o_done, o_pass, o_timeout, o_err_count, o_first_fail_idx
  );
endinterface

// File: rtl/mips_test_monitor_slot_file.sv
// monitor_slot_file: watched address, expected value, shadow and written bit per slot
module monitor_slot_file #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_CHECKS = 4,
  parameter int IDX_W    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_cfg_we,
  input  logic [IDX_W-1:0]  i_cfg_idx,
  input  logic [ADDR_W-1:0] i_cfg_addr,
  input  logic [DATA_W-1:0] i_cfg_data,
  input  logic              i_snoop_we,
  input  logic [ADDR_W-1:0] i_snoop_addr,
  input  logic [DATA_W-1:0] i_snoop_wdata,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_mismatch
);
  logic [ADDR_W-1:0] addr_q   [N_CHECKS];
  logic [DATA_W-1:0] exp_q    [N_CHECKS];
  logic [DATA_W-1:0] shadow_q [N_CHECKS];
  logic              written_q[N_CHECKS];
  // Config writes only hit existing slots; every matching slot captures a snooped write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_CHECKS; k++) begin
        addr_q[k]    <= '0;
        exp_q[k]     <= '0;
        shadow_q[k]  <= '0;
        written_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < N_CHECKS; k++) begin
        if (i_cfg_we && i_cfg_idx == IDX_W'(k)) begin
          addr_q[k] <= i_cfg_addr;
          exp_q[k]  <= i_cfg_data;
        end
        if (i_clr) begin
          shadow_q[k]  <= '0;
          written_q[k] <= 1'b0;
        end else if (i_snoop_we && i_snoop_addr == addr_q[k]) begin
          shadow_q[k]  <= i_snoop_wdata;
          written_q[k] <= 1'b1;
        end
      end
    end
  end
  assign o_rd_mismatch = !written_q[i_rd_idx] || shadow_q[i_rd_idx] != exp_q[i_rd_idx];
endmodule

// File: rtl/mips_test_monitor.sv
// mips_test_monitor: snoops core data writes and reports pass/fail/timeout of a regression run
module mips_test_monitor
  import mips_tb_pkg::*;
#(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter int              N_CHECKS       = 4,
  parameter logic [ADDR_W-1:0] DONE_ADDR    = '0,
  parameter int              DONE_BIT       = 0,
  parameter int              TIMEOUT_CYCLES = 100000
) (
  input logic i_clk,
  input logic i_rst_n,
  mips_test_monitor_if.slave bus
);
  localparam int IDX_W = idx_w(N_CHECKS);
  localparam int CNT_W = cnt_w(N_CHECKS);
  localparam int TMO_W = timeout_w(TIMEOUT_CYCLES);
  mon_state_e       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [IDX_W-1:0] idx_q, idx_d, ff_q, ff_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic trk_q, trk_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d, tflag_q, tflag_d;
  logic start_run, done_addr_hit, done_wr, tmo_hit, mismatch;
  assign start_run     = bus.i_start && (state_q == IDLE || state_q == DONE);
  assign done_addr_hit = state_q == RUN && bus.i_mem_we && bus.i_mem_addr == DONE_ADDR;
  assign done_wr       = done_addr_hit && bus.i_mem_wdata[DONE_BIT] && !trk_q;
  assign tmo_hit       = tmo_q == TMO_W'(TIMEOUT_CYCLES - 1);
  monitor_slot_file #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_CHECKS(N_CHECKS), .IDX_W(IDX_W)
  ) u_slots (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (start_run),
    .i_cfg_we     (bus.i_cfg_we && state_q == IDLE),
    .i_cfg_idx    (bus.i_cfg_idx),
    .i_cfg_addr   (bus.i_cfg_addr),
    .i_cfg_data   (bus.i_cfg_data),
    .i_snoop_we   (state_q == RUN && bus.i_mem_we),
    .i_snoop_addr (bus.i_mem_addr),
    .i_snoop_wdata(bus.i_mem_wdata),
    .i_rd_idx     (idx_q),
    .o_rd_mismatch(mismatch)
  );
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  // Next state; a done write takes priority over timeout in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start_run ? RUN : IDLE;
      RUN:     state_d = done_wr ? COMPARE : tmo_hit ? DONE : RUN;
      COMPARE: state_d = (idx_q == IDX_W'(N_CHECKS - 1)) ? DONE : COMPARE;
      DONE:    state_d = start_run ? RUN : DONE;
    endcase
  end
  // Datapath and status next values; err_q still zero marks the first mismatch
  always_comb begin
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    trk_d   = trk_q;
    err_d   = err_q;
    ff_d    = ff_q;
    tflag_d = tflag_q;
    if (start_run) begin
      tmo_d   = '0;
      idx_d   = '0;
      trk_d   = 1'b0;
      err_d   = '0;
      ff_d    = '0;
      tflag_d = 1'b0;
    end else if (state_q == RUN) begin
      tmo_d   = tmo_q + 1'b1;
      trk_d   = done_addr_hit ? bus.i_mem_wdata[DONE_BIT] : trk_q;
      tflag_d = !done_wr && tmo_hit;
    end else if (state_q == COMPARE) begin
      idx_d = idx_q + 1'b1;
      err_d = err_q + CNT_W'(mismatch);
      ff_d  = (mismatch && err_q == '0) ? idx_q : ff_q;
    end
    busy_d = state_d == RUN || state_d == COMPARE;
    done_d = state_d == DONE;
    pass_d = done_d && err_d == '0 && !tflag_d;
  end
  // Datapath and status registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_q   <= '0;
      idx_q   <= '0;
      trk_q   <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      tflag_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      trk_q   <= trk_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      tflag_q <= tflag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  assign bus.o_busy           = busy_q;
  assign bus.o_done           = done_q;
  assign bus.o_pass           = pass_q;
  assign bus.o_timeout        = tflag_q;
  assign bus.o_err_count      = err_q;
  assign bus.o_first_fail_idx = ff_q;
endmodule

// File: tb/tb_mips_test_monitor.sv
// tb_mips_test_monitor: directed scoreboard bench for the regression pass/fail monitor
module tb_mips_test_monitor;
  localparam int N = 4;
  localparam int TMO = 50;
  localparam logic [31:0] DA = 32'h80;
  typedef struct {
    logic pass;
    logic tmo;
    int   err;
    int   ff;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vec = 0;
  int misc = 0;
  exp_t sb[$];
  logic [31:0] m_addr[N];
  logic [31:0] m_exp[N];
  logic [31:0] m_sh[N];
  logic        m_wr[N];
  logic m_idle, m_run, m_trk;
  mips_test_monitor_if #(.ADDR_W(32), .DATA_W(32), .N_CHECKS(N)) bus ();
  mips_test_monitor #(
    .ADDR_W(32), .DATA_W(32), .N_CHECKS(N), .DONE_ADDR(DA), .DONE_BIT(0), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.o_busy), 0);
    check({tag, "_done"}, 32'(bus.o_done), 0);
    check({tag, "_pass"}, 32'(bus.o_pass), 0);
    check({tag, "_timeout"}, 32'(bus.o_timeout), 0);
    check({tag, "_err"}, 32'(bus.o_err_count), 0);
    check({tag, "_ff"}, 32'(bus.o_first_fail_idx), 0);
  endtask
  task automatic model_reset();
    m_idle = 1'b1;
    m_run = 1'b0;
    m_trk = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_addr[k] = '0;
      m_exp[k] = '0;
      m_sh[k] = '0;
      m_wr[k] = 1'b0;
    end
  endtask
  function automatic exp_t model_result();
    exp_t r;
    r.err = 0;
    r.ff = 0;
    r.tmo = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!m_wr[k] || m_sh[k] != m_exp[k]) begin
        if (r.err == 0) r.ff = k;
        r.err++;
      end
    end
    r.pass = r.err == 0;
    return r;
  endfunction
  task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
    bus.i_cfg_we = 1'b1;
    bus.i_cfg_idx = 2'(idx);
    bus.i_cfg_addr = a;
    bus.i_cfg_data = d;
    step();
    bus.i_cfg_we = 1'b0;
    if (m_idle) begin
      m_addr[idx] = a;
      m_exp[idx] = d;
    end
  endtask
  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    bus.i_mem_we = 1'b1;
    bus.i_mem_addr = a;
    bus.i_mem_wdata = d;
    step();
    bus.i_mem_we = 1'b0;
    if (m_run) begin
      for (int k = 0; k < N; k++) begin
        if (m_addr[k] == a) begin
          m_sh[k] = d;
          m_wr[k] = 1'b1;
        end
      end
      if (a == DA) begin
        if (d[0] && !m_trk) begin
          m_run = 1'b0;
          sb.push_back(model_result());
        end
        m_trk = d[0];
      end
    end
  endtask
  task automatic start_run(input string tag);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    m_idle = 1'b0;
    m_run = 1'b1;
    m_trk = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_sh[k] = '0;
      m_wr[k] = 1'b0;
    end
    check({tag, "_busy_after_start"}, 32'(bus.o_busy), 1);
    check({tag, "_done_after_start"}, 32'(bus.o_done), 0);
    check({tag, "_pass_after_start"}, 32'(bus.o_pass), 0);
  endtask
  task automatic finish_run(input string tag, input int lat);
    int n = 0;
    exp_t e;
    while (!bus.o_done && n < 200) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    if (sb.size() == 0) begin
      vec++;
      misc++;
      $error("FAIL %s_scoreboard: observed empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_pass"}, 32'(bus.o_pass), 32'(e.pass));
      check({tag, "_timeout"}, 32'(bus.o_timeout), 32'(e.tmo));
      check({tag, "_err"}, 32'(bus.o_err_count), 32'(e.err));
      check({tag, "_ff"}, 32'(bus.o_first_fail_idx), 32'(e.ff));
      check({tag, "_busy"}, 32'(bus.o_busy), 0);
    end
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_cfg_we = 1'b0;
    bus.i_cfg_idx = '0;
    bus.i_cfg_addr = '0;
    bus.i_cfg_data = '0;
    bus.i_mem_we = 1'b0;
    bus.i_mem_addr = '0;
    bus.i_mem_wdata = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("in_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check_zero("idle_after_reset");
    cfg(0, 32'h10, 32'h15);
    cfg(1, 32'h14, 32'h22);
    cfg(2, 32'h18, 32'h33);
    cfg(3, 32'h1C, 32'h44);
    start_run("basic");
    mem_wr(32'h10, 32'h15);
    mem_wr(32'h14, 32'h22);
    mem_wr(32'h18, 32'h33);
    mem_wr(32'h1C, 32'h44);
    mem_wr(DA, 32'h1);
    finish_run("basic", N);
    cfg(0, 32'h10, 32'h77);
    start_run("mixed");
    mem_wr(32'h10, 32'h15);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    check("mixed_start_ignored_busy", 32'(bus.o_busy), 1);
    mem_wr(32'h14, 32'h99);
    mem_wr(32'h1C, 32'h98);
    mem_wr(DA, 32'h1);
    finish_run("mixed", N);
    start_run("timeout");
    m_run = 1'b0;
    sb.push_back('{pass: 1'b0, tmo: 1'b1, err: 0, ff: 0});
    finish_run("timeout", TMO);
    start_run("done_wins");
    mem_wr(32'h10, 32'h15);
    mem_wr(32'h14, 32'h22);
    mem_wr(32'h18, 32'h33);
    mem_wr(32'h1C, 32'h44);
    repeat (TMO - 5) step();
    mem_wr(DA, 32'h1);
    finish_run("done_wins", N);
    start_run("double_done");
    mem_wr(DA, 32'h1);
    mem_wr(DA, 32'h1);
    finish_run("double_done", N - 1);
    repeat (6) step();
    check("double_done_sticky_done", 32'(bus.o_done), 1);
    check("double_done_sticky_err", 32'(bus.o_err_count), 4);
    start_run("rearm");
    mem_wr(DA, 32'h0);
    mem_wr(DA, 32'h1);
    finish_run("rearm", N);
    start_run("abort");
    mem_wr(DA, 32'h1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_compare");
    sb.delete();
    model_reset();
    #2 rst_n = 1'b1;
    step();
    check_zero("idle_after_abort");
    cfg(0, 32'h20, 32'hAB);
    cfg(1, 32'h24, 32'h1);
    cfg(2, 32'h20, 32'hAB);
    cfg(3, DA, 32'h1);
    start_run("shared");
    mem_wr(32'h20, 32'hAB);
    mem_wr(32'h24, 32'h1);
    mem_wr(DA, 32'h1);
    finish_run("shared", N);
    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end
endmodule
